// File: rtl/dram_backing_store_pkg.sv
// Shared types, constants and helpers for the DRAM backing store.
package dram_pkg;

    // Widest statistics counter carried by dram_stats_t.
    localparam int unsigned DRAM_STATS_MAX_W = 64;

    // Fill bit for read data returned on an out-of-range read.
    localparam bit DRAM_ERR_READ_DATA = 1'b0;

    // Bundle of the four statistics counters.
    typedef struct packed {
        logic [DRAM_STATS_MAX_W-1:0] rd;
        logic [DRAM_STATS_MAX_W-1:0] wr;
        logic [DRAM_STATS_MAX_W-1:0] hit;
        logic [DRAM_STATS_MAX_W-1:0] miss;
    } dram_stats_t;

    // log2 of the number of bytes in a data word.
    function automatic int unsigned nr_bytes_log2(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/dram_backing_store_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import dram_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dram_backing_store.sv
// Zero-wait-state word memory behind the AXI-to-DRAM bridge, with
// open-row hit/miss tracking and saturating access statistics.
module dram_backing_store
    import dram_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 64,
    parameter int unsigned            DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(64'h8000_0000),
    parameter int unsigned            NUM_WORDS  = 16384,
    parameter int unsigned            ROW_BYTES  = 2048,
    parameter int unsigned            CNT_WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      err_o,
    input  logic                      clear_stats_i,
    output logic [CNT_WIDTH-1:0]      rd_cnt_o,
    output logic [CNT_WIDTH-1:0]      wr_cnt_o,
    output logic [CNT_WIDTH-1:0]      hit_cnt_o,
    output logic [CNT_WIDTH-1:0]      miss_cnt_o
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = nr_bytes_log2(DATA_WIDTH);
    localparam int unsigned WORD_AW    = $clog2(NUM_WORDS);
    localparam int unsigned ROW_SHIFT  = $clog2(ROW_BYTES);
    localparam int unsigned ROW_W      = ADDR_WIDTH - ROW_SHIFT;
    localparam logic [ADDR_WIDTH-1:0] SPAN_BYTES =
        ADDR_WIDTH'(64'(NUM_WORDS) * 64'(BYTES));

    // Storage array; deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [ADDR_WIDTH-1:0] off_c;
    logic                  in_range_c;
    logic [WORD_AW-1:0]    word_c;
    logic [ROW_W-1:0]      row_c;
    logic                  row_hit_c;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  err_q;
    logic                  err_d;
    logic [ROW_W-1:0]      open_row_q;
    logic [ROW_W-1:0]      open_row_d;
    logic                  open_row_valid_q;
    logic                  open_row_valid_d;

    logic                  rd_inc_c;
    logic                  wr_inc_c;
    logic                  hit_inc_c;
    logic                  miss_inc_c;

    // Address decode relative to the base of the store.
    always_comb begin
        off_c      = addr_i - BASE_ADDR;
        in_range_c = (addr_i >= BASE_ADDR) && (off_c < SPAN_BYTES);
        word_c     = off_c[BYTE_SHIFT +: WORD_AW];
        row_c      = off_c[ADDR_WIDTH-1:ROW_SHIFT];
        row_hit_c  = open_row_valid_q && (row_c == open_row_q);
    end

    // Read data and error pulse next state.
    always_comb begin
        data_d = data_q;
        err_d  = req_i && !in_range_c;
        if (req_i && !we_i) begin
            data_d = in_range_c ? mem[word_c]
                                : {DATA_WIDTH{DRAM_ERR_READ_DATA}};
        end
    end

    // Open-row next state; a stats clear closes the row.
    always_comb begin
        open_row_d       = open_row_q;
        open_row_valid_d = open_row_valid_q;
        if (req_i && in_range_c && !row_hit_c) begin
            open_row_d       = row_c;
            open_row_valid_d = 1'b1;
        end
        if (clear_stats_i) begin
            open_row_valid_d = 1'b0;
        end
    end

    // Statistics increment strobes.
    always_comb begin
        rd_inc_c   = req_i && !we_i;
        wr_inc_c   = req_i && we_i;
        hit_inc_c  = req_i && in_range_c && row_hit_c;
        miss_inc_c = req_i && in_range_c && !row_hit_c;
    end

    // Byte-masked array write for in-range write requests.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i && in_range_c) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (be_i[b]) begin
                    mem[word_c][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    // Output and open-row registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q           <= '0;
            err_q            <= 1'b0;
            open_row_q       <= '0;
            open_row_valid_q <= 1'b0;
        end else begin
            data_q           <= data_d;
            err_q            <= err_d;
            open_row_q       <= open_row_d;
            open_row_valid_q <= open_row_valid_d;
        end
    end

    assign data_o = data_q;
    assign err_o  = err_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_stats_i),
        .inc_i (rd_inc_c),
        .cnt_o (rd_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_stats_i),
        .inc_i (wr_inc_c),
        .cnt_o (wr_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_stats_i),
        .inc_i (hit_inc_c),
        .cnt_o (hit_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_stats_i),
        .inc_i (miss_inc_c),
        .cnt_o (miss_cnt_o)
    );

endmodule

// File: tb/tb_dram_backing_store.sv
// Directed scoreboard bench for dram_backing_store (4-bit counters).
module tb_dram_backing_store;
    import dram_pkg::*;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned NW = 16384;
    localparam int unsigned RB = 2048;
    localparam int unsigned CW = 4;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'(NW) * 64'd8;
    localparam logic [63:0] CMAX = 64'd15;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [63:0]   addr_i = '0;
    logic [7:0]    be_i = '0;
    logic [63:0]   data_i = '0;
    logic          clear_stats_i = 1'b0;
    logic [63:0]   data_o;
    logic          err_o;
    logic [CW-1:0] rd_cnt_o;
    logic [CW-1:0] wr_cnt_o;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [63:0] mdl_mem [logic [63:0]];
    logic [63:0] rdq [$];
    dram_stats_t ms = '0;
    logic [63:0] orow = '0;
    bit          orv = 1'b0;
    logic [63:0] hold = '0;
    bit          exp_err = 1'b0;

    dram_backing_store #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .NUM_WORDS  (NW),
        .ROW_BYTES  (RB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .be_i          (be_i),
        .data_i        (data_i),
        .data_o        (data_o),
        .err_o         (err_o),
        .clear_stats_i (clear_stats_i),
        .rd_cnt_o      (rd_cnt_o),
        .wr_cnt_o      (wr_cnt_o),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input logic [63:0] v);
        return (v == CMAX) ? v : v + 64'd1;
    endfunction

    task automatic chk_cnts();
        chk("rd_cnt",   64'(rd_cnt_o),   ms.rd);
        chk("wr_cnt",   64'(wr_cnt_o),   ms.wr);
        chk("hit_cnt",  64'(hit_cnt_o),  ms.hit);
        chk("miss_cnt", 64'(miss_cnt_o), ms.miss);
    endtask

    // One request cycle: update model, clock DUT, compare outputs.
    task automatic step(input bit req, input bit we, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] data, input bit clr);
        logic [63:0] off;
        logic [63:0] word;
        logic [63:0] row;
        logic [63:0] cur;
        bit          inr;
        req_i = req; we_i = we; addr_i = addr; be_i = be; data_i = data;
        clear_stats_i = clr;
        off  = addr - BASE;
        inr  = (addr >= BASE) && (off < SPAN);
        word = off >> 3;
        row  = off >> 11;
        exp_err = req && !inr;
        if (req) begin
            if (we) begin
                ms.wr = sat(ms.wr);
                if (inr) begin
                    cur = mdl_mem.exists(word) ? mdl_mem[word] : 64'h0;
                    for (int b = 0; b < 8; b++)
                        if (be[b]) cur[8*b +: 8] = data[8*b +: 8];
                    mdl_mem[word] = cur;
                end
            end else begin
                ms.rd = sat(ms.rd);
                if (!inr)                    rdq.push_back(64'h0);
                else if (mdl_mem.exists(word)) rdq.push_back(mdl_mem[word]);
                else                          rdq.push_back(64'bx);
            end
            if (inr) begin
                if (orv && row == orow) begin
                    ms.hit = sat(ms.hit);
                end else begin
                    ms.miss = sat(ms.miss);
                    orow = row;
                    orv  = 1'b1;
                end
            end
        end
        if (clr) begin
            ms  = '0;
            orv = 1'b0;
        end
        @(posedge clk_i);
        #1;
        if (rdq.size() > 0) begin
            hold = rdq.pop_front();
            chk("rd_data", data_o, hold);
        end else begin
            chk("data_hold", data_o, hold);
        end
        chk("err", 64'(err_o), 64'(exp_err));
        chk_cnts();
        req_i = 1'b0; we_i = 1'b0; clear_stats_i = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a);
        step(1'b1, 1'b0, a, 8'h00, 64'h0, 1'b0);
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] be, input logic [63:0] d);
        step(1'b1, 1'b1, a, be, d, 1'b0);
    endtask

    // Mid-cycle asynchronous reset pulse spanning one clock edge.
    task automatic pulse_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_async_data", data_o, 64'h0);
        chk("rst_async_err",  64'(err_o), 64'h0);
        ms = '0; orv = 1'b0; hold = '0; rdq.delete();
        chk_cnts();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_data", data_o, 64'h0);
        chk("por_err",  64'(err_o), 64'h0);
        chk_cnts();
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        step(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);

        // Full write then read-after-write
        wr(64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF);
        rd(64'h8000_0000);
        chk("t1_data", data_o, 64'h0123_4567_89AB_CDEF);
        chk("t1_counts", {60'h0, rd_cnt_o, wr_cnt_o, hit_cnt_o, miss_cnt_o} & 64'hFFFF,
            64'h1111);

        // Partial write keeps unselected bytes
        wr(64'h8000_0000, 8'h0F, 64'hFFFF_FFFF_0000_0000);
        rd(64'h8000_0000);
        chk("t2_data", data_o, 64'h0123_4567_0000_0000);

        // Streaming reads across rows
        wr(64'h8000_0008, 8'hFF, 64'h1111_2222_3333_4444);
        wr(64'h8000_0800, 8'hFF, 64'h5555_6666_7777_8888);
        wr(64'h8000_0010, 8'hFF, 64'h9999_AAAA_BBBB_CCCC);
        step(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
        rd(64'h8000_0000);
        rd(64'h8000_0008);
        rd(64'h8000_0800);
        chk("t3_row1_data", data_o, 64'h5555_6666_7777_8888);
        rd(64'h8000_0010);
        chk("t3_hits",   64'(hit_cnt_o),  64'd1);
        chk("t3_misses", 64'(miss_cnt_o), 64'd3);

        // Out-of-range below base and past the end
        rd(64'h7FFF_FFF8);
        chk("t4_err_rd", 64'(err_o), 64'h1);
        wr(64'h8002_0000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t4_err_wr", 64'(err_o), 64'h1);
        rd(64'h8000_0000);
        chk("t4_unchanged", data_o, 64'h0123_4567_0000_0000);
        wr(64'h8001_FFF8, 8'hFF, 64'hCAFE_F00D_0000_0001);
        rd(64'h8001_FFF8);
        chk("t4_last_word", data_o, 64'hCAFE_F00D_0000_0001);

        // Counter saturation and clear-wins
        step(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) rd(64'h8000_0008);
        chk("t5_rd_sat", 64'(rd_cnt_o), 64'd15);
        step(1'b1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 1'b1);
        chk("t5_rd_clr", 64'(rd_cnt_o), 64'd0);
        chk("t5_clr_data", data_o, 64'h9999_AAAA_BBBB_CCCC);

        // Reset in the middle of a read burst
        rd(64'h8000_0000);
        rd(64'h8000_0008);
        pulse_reset();
        step(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        rd(64'h8000_0008);
        chk("t6_data", data_o, 64'h1111_2222_3333_4444);
        chk("t6_miss", 64'(miss_cnt_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
